// File: rtl/wave_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wave_capture: captures one zero-crossing-aligned frame of audio samples     |
// | into a double-buffered display RAM, swapping banks only when display idle.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module wave_capture #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              new_sample_ready,
   input  logic [15:0]       new_sample_in,
   input  logic              wave_display_idle,
   output logic [ADDR_W:0]   write_address,
   output logic              write_enable,
   output logic [7:0]        write_sample,
   output logic              read_index
);

   localparam logic [1:0] c_armed  = 2'd0;
   localparam logic [1:0] c_active = 2'd1;
   localparam logic [1:0] c_wait   = 2'd2;

   localparam logic [ADDR_W-1:0] c_last = {ADDR_W{1'b1}};

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] w_index;
   logic [ADDR_W-1:0] w_count_next;
   logic              r_prev_sign;
   logic              w_crossing;
   logic              w_write;
   logic              w_swap;
   logic              w_unused_lsbs;

   // The low byte never reaches the 8-bit display RAM.
   assign w_unused_lsbs = ^new_sample_in[7:0];

   // Positive-going crossing; 0x0000 has sign 0 and so counts as non-negative.
   assign w_crossing   = r_prev_sign & ~new_sample_in[15];
   assign w_count_next = w_index + ADDR_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_armed;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_armed:  if (new_sample_ready && w_crossing)         w_state_next = c_active;
         c_active: if (new_sample_ready && r_count == c_last)  w_state_next = c_wait;
         c_wait:   if (wave_display_idle)                      w_state_next = c_armed;
         default:                                              w_state_next = c_armed;
      endcase
   end

   always_comb begin
      w_write = 1'b0;
      w_index = r_count;
      w_swap  = 1'b0;
      case (r_state)
         c_armed: begin
            if (new_sample_ready && w_crossing) begin
               w_write = 1'b1;
               w_index = '0;
            end
         end
         c_active: w_write = new_sample_ready;
         c_wait:   w_swap  = wave_display_idle;
         default: ;
      endcase
   end

   // Index counter wraps to zero naturally after the last write of a frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_enable  <= 1'b0;
         write_address <= '0;
         write_sample  <= '0;
         read_index    <= 1'b0;
         r_count       <= '0;
         r_prev_sign   <= 1'b0;
      end else begin
         write_enable <= w_write;
         if (w_write) begin
            write_address <= {~read_index, w_index};
            write_sample  <= {~new_sample_in[15], new_sample_in[14:8]};
            r_count       <= w_count_next;
         end
         if (new_sample_ready) begin
            r_prev_sign <= new_sample_in[15];
         end
         if (w_swap) begin
            read_index <= ~read_index;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wave_capture.sv
`default_nettype none
// Testbench for wave_capture: directed steps plus random traffic checked
// against a frame-position model of the capture behaviour.
module tb_wave_capture;

   localparam int N = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        new_sample_ready;
   logic [15:0] new_sample_in;
   logic        wave_display_idle;
   logic [8:0]  write_address;
   logic        write_enable;
   logic [7:0]  write_sample;
   logic        read_index;

   int n_checks = 0;
   int n_err    = 0;

   // Model: pos = -1 waiting for a crossing, 0..N-1 next frame slot, N frame full.
   int       pos;
   bit       m_prev;
   bit       m_ri;
   bit       exp_we;
   int       exp_addr;
   int       exp_ws;

   wave_capture #(.ADDR_W(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .new_sample_ready  (new_sample_ready),
      .new_sample_in     (new_sample_in),
      .wave_display_idle (wave_display_idle),
      .write_address     (write_address),
      .write_enable      (write_enable),
      .write_sample      (write_sample),
      .read_index        (read_index)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      pos = -1; m_prev = 0; m_ri = 0;
      exp_we = 0; exp_addr = 0; exp_ws = 0;
   endtask

   task automatic model_write(input int idx, input logic [15:0] s);
      int hi;
      exp_we   = 1;
      exp_addr = (m_ri ? 0 : N) + idx;
      hi       = int'(s[15:8]);
      exp_ws   = (hi + 128) % 256;   // offset binary
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_we"},   int'(write_enable),  int'(exp_we));
      chk({tag, "_addr"}, int'(write_address), exp_addr);
      chk({tag, "_ws"},   int'(write_sample),  exp_ws);
      chk({tag, "_ri"},   int'(read_index),    int'(m_ri));
   endtask

   task automatic cycle(input bit r, input logic [15:0] s, input bit idl, input string tag);
      new_sample_ready  = r;
      new_sample_in     = s;
      wave_display_idle = idl;
      exp_we = 0;
      if (pos == N) begin
         if (idl) begin
            m_ri = ~m_ri;
            pos  = -1;
         end
      end else if (r) begin
         if (pos < 0) begin
            if (m_prev && !s[15]) begin
               model_write(0, s);
               pos = 1;
            end
         end else begin
            model_write(pos, s);
            pos++;
         end
      end
      if (r) m_prev = s[15];
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      logic [15:0] false_trig [5];
      false_trig[0] = 16'h1000; false_trig[1] = 16'h2000; false_trig[2] = 16'h7FFF;
      false_trig[3] = 16'hFFFF; false_trig[4] = 16'h8000;

      reset = 1'b0; new_sample_ready = 1'b0; new_sample_in = '0; wave_display_idle = 1'b0;
      model_reset();
      repeat (3) begin
         new_sample_ready = 1'b1;
         new_sample_in    = 16'($urandom);
         @(posedge clk); #1;
         check_outputs("reset");
      end
      reset = 1'b1;
      cycle(0, 16'h0, 0, "idle");

      foreach (false_trig[i]) begin
         cycle(1, false_trig[i], 0, "false_trig");
         chk("false_trig_we", int'(write_enable), 0);
      end

      cycle(1, 16'hF000, 0, "pre_cross");
      cycle(1, 16'h0010, 0, "cross");
      chk("cross_we", int'(write_enable), 1);
      chk("cross_addr", int'(write_address), 'h100);
      chk("cross_ws", int'(write_sample), 'h80);

      for (int i = 0; i < N - 1; i++) begin
         if ($urandom_range(0, 2) == 0) cycle(0, 16'($urandom), 0, "frame_gap");
         cycle(1, 16'($urandom), 0, "frame");
      end
      chk("frame_last_addr", int'(write_address), 'h1FF);
      repeat (6) cycle(1, 16'($urandom), 0, "frame_drop");
      chk("pre_swap_ri", int'(read_index), 0);
      cycle(0, 16'h0, 1, "swap");
      chk("swap_ri", int'(read_index), 1);

      cycle(1, 16'h8000, 0, "f2_pre");
      cycle(1, 16'h0000, 0, "f2_cross");
      chk("f2_addr", int'(write_address), 'h000);
      chk("f2_ws", int'(write_sample), 'h80);
      for (int i = 0; i < 99; i++) cycle(1, 16'($urandom), 0, "f2_body");

      reset = 1'b0;
      #1;
      model_reset();
      chk("midrst_we",   int'(write_enable),  0);
      chk("midrst_addr", int'(write_address), 0);
      chk("midrst_ws",   int'(write_sample),  0);
      chk("midrst_ri",   int'(read_index),    0);
      @(posedge clk); #1;
      reset = 1'b1;
      cycle(1, 16'h1234, 0, "rearm_pos");
      cycle(1, 16'h8001, 0, "rearm_neg");
      cycle(1, 16'h0100, 0, "rearm_cross");
      chk("rearm_addr", int'(write_address), 'h100);
      chk("rearm_ws", int'(write_sample), 'h81);

      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 7) == 0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Consumes the 16-bit sample stream and one-cycle sample strobe produced by the music player.
- Captures one display frame of 2^ADDR_W samples, starting at a positive-going zero crossing.
- Writes the frame into one half of a double-buffered sample RAM that the waveform display reads.
- Swaps buffer halves only when the display reports it is idle, so a frame is never torn.

Parameters:
- ADDR_W, 8, log2 of samples per frame (256 samples per frame by default).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle
- new_sample_in  input  16  signed two's-complement audio sample
- wave_display_idle  input  1  high while the display is not reading the RAM
- write_address  output  ADDR_W+1  RAM write address: {bank, index}
- write_enable  output  1  one-cycle RAM write strobe
- write_sample  output  8  offset-binary sample: new_sample_in[15:8] with bit 7 inverted
- read_index  output  1  bank the display reads; the capture side writes bank ~read_index

Behaviour:
- Reset (reset==0, asynchronous):
  - state=ARMED, index counter=0, prev_sign=0, read_index=0.
  - write_enable=0, write_address=0, write_sample=0.
- All outputs are registered. A write appears on the outputs 1 cycle after the new_sample_ready that caused it.
- prev_sign <= new_sample_in[15] on every new_sample_ready cycle, in every state.
- A crossing is a new_sample_ready cycle with prev_sign==1 and new_sample_in[15]==0.
  - 0x0000 counts as non-negative.
- State ARMED:
  - No writes.
  - On a crossing: write the crossing sample at index 0, set counter=1, go to ACTIVE.
  - Non-crossing samples are ignored.
- State ACTIVE:
  - On each new_sample_ready: write at {~read_index, counter}, then counter++.
  - The write at counter==2^ADDR_W-1 is the last of the frame: counter wraps to 0, go to WAIT.
  - Crossings are ignored in ACTIVE.
- State WAIT:
  - No writes; samples are dropped (prev_sign still tracks them).
  - When wave_display_idle==1: toggle read_index, go to ARMED.
  - The toggle is visible the next cycle.
- write_address bank bit is always ~read_index as sampled in the write cycle. The capture side never writes the bank being displayed.
- write_sample:
  - Equals {~new_sample_in[15], new_sample_in[14:8]}.
  - Latched only on write cycles; holds its value otherwise.
- write_enable is high for exactly one cycle per accepted sample and never on two consecutive new_sample_ready-free cycles.
- Simultaneous events:
  - new_sample_ready in the same cycle as the WAIT->ARMED transition: the sample updates prev_sign but cannot trigger a crossing.
  - wave_display_idle outside WAIT has no effect.
- Reset mid-frame: the partially written frame is abandoned, read_index returns to 0, and capture re-arms.

Test Plan:
- Reset behaviour: hold reset=0 for 3 cycles with strobes active.
  - Required: write_enable=0, read_index=0, write_address=0, state ARMED.
- Zero-crossing capture: samples 0xF000 then 0x0010.
  - Required: one cycle later, write_enable=1, write_address=0x100, write_sample=0x80.
- False triggers: feed 0x1000, 0x2000, 0x7FFF, then 0xFFFF, 0x8000.
  - Required: no write_enable pulses while ARMED.
- Full frame: after a crossing, feed 255 more samples with display idle=0.
  - Required: addresses 0x100..0x1FF, written in order, then no further writes.
  - Required: on raising idle, read_index goes 0->1 one cycle later.
- Second frame: after the swap, trigger a crossing on 0x8000 then 0x0000.
  - Required: the first write is at address 0x000, write_sample=0x80.
- Mid-frame reset: assert reset after 100 writes.
  - Required: outputs clear immediately (asynchronously).
  - Required: after release, writes resume only after a new crossing, at index 0, bank 1.
